cl_frame_gen: RTL and testbench

//  Camera Link source emulator: drives cl_fval/cl_lval/cl_data with frame/line/pixel timing
//  and a self-checking data pattern. Pairs with the capture block and the CL loopback

---
 rtl/cl_frame_gen_pkg.sv | 29 ++
 rtl/cl_frame_gen_if.sv | 23 ++
 rtl/cl_frame_gen_pattern.sv | 26 ++
 rtl/cl_frame_gen.sv | 159 +++++++++++++++
 tb/tb_cl_frame_gen.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cl_frame_gen_pkg.sv
// Shared constants, state encoding and the pixel-word formatter for the Camera Link source emulator.
package cl_frame_gen_pkg;

   localparam logic [11:0] CL_OP_STOP   = 12'h000;
   localparam logic [11:0] CL_OP_RUN    = 12'h001;
   localparam int          N_FRAME_SIZE = 20;
   localparam int          N_LINE_SIZE  = 12;
   localparam int          N_CLK_SIZE   = 10;
   localparam int          BLANK_SIZE   = 16;
   localparam int          CL_DATA_W    = 80;
   localparam logic [7:0]  CL_PAT_TAG   = 8'hA5;

   typedef enum logic [1:0] {
      ST_STANDBY = 2'd0,
      ST_VBLANK  = 2'd1,
      ST_HBLANK  = 2'd2,
      ST_ACTIVE  = 2'd3
   } gen_state_t;

   // Same layout is used by the capture-side checker to validate received words.
   function automatic logic [CL_DATA_W-1:0] cl_pattern(
      input logic [N_FRAME_SIZE-1:0] frame_idx,
      input logic [N_LINE_SIZE-1:0]  line,
      input logic [N_CLK_SIZE-1:0]   clk_cnt
   );
      return {CL_PAT_TAG, frame_idx, 4'h0, line, 6'h0, clk_cnt, ~frame_idx};
   endfunction

endpackage

// File: rtl/cl_frame_gen_if.sv
// PC message handshake plus Camera Link video outputs of the frame generator.
interface cl_frame_gen_if;
   import cl_frame_gen_pkg::*;

   logic                 pc_msg_pending;
   logic [31:0]          pc_msg;
   logic                 pc_msg_ack;
   logic                 cl_fval;
   logic                 cl_lval;
   logic [CL_DATA_W-1:0] cl_data;
   logic                 gen_busy;
   logic                 gen_done;

   modport master (
      output pc_msg_pending, pc_msg,
      input  pc_msg_ack, cl_fval, cl_lval, cl_data, gen_busy, gen_done
   );

   modport slave (
      input  pc_msg_pending, pc_msg,
      output pc_msg_ack, cl_fval, cl_lval, cl_data, gen_busy, gen_done
   );
endinterface

// File: rtl/cl_frame_gen_pattern.sv
// Registered formatter: turns (frame_idx, line, clk, lval) into the 80-bit self-checking pixel word.
module cl_frame_gen_pattern
   import cl_frame_gen_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_FRAME_SIZE-1:0] frame_idx,
   input  logic [N_LINE_SIZE-1:0]  line,
   input  logic [N_CLK_SIZE-1:0]   clk_cnt,
   input  logic                    lval,
   output logic [CL_DATA_W-1:0]    data
);

   logic [CL_DATA_W-1:0] data_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg <= '0;
      end else begin
         data_reg <= lval ? cl_pattern(frame_idx, line, clk_cnt) : '0;
      end
   end

   assign data = data_reg;

endmodule

// File: rtl/cl_frame_gen.sv
// Camera Link source emulator: frame/line/pixel timing FSM, blank counters and PC message handshake.
module cl_frame_gen
   import cl_frame_gen_pkg::*;
#(
   parameter int N_LINE  = 4,
   parameter int N_CLK   = 8,
   parameter int H_BLANK = 2,
   parameter int V_BLANK = 3
) (
   input  logic           cl_clk,
   input  logic           reset,
   cl_frame_gen_if.slave  bus
);

   localparam logic [BLANK_SIZE-1:0]  V_LAST    = BLANK_SIZE'(V_BLANK - 1);
   localparam logic [BLANK_SIZE-1:0]  H_LAST    = BLANK_SIZE'(H_BLANK - 1);
   localparam logic [N_LINE_SIZE-1:0] LINE_LAST = N_LINE_SIZE'(N_LINE - 1);
   localparam logic [N_CLK_SIZE-1:0]  CLK_LAST  = N_CLK_SIZE'(N_CLK - 1);

   gen_state_t              state_reg, state_next;
   logic [BLANK_SIZE-1:0]   blank_reg, blank_next;
   logic [N_LINE_SIZE-1:0]  line_reg, line_next;
   logic [N_CLK_SIZE-1:0]   clk_reg, clk_next;
   logic [N_FRAME_SIZE-1:0] frame_left_reg, frame_left_next;
   logic [N_FRAME_SIZE-1:0] frame_idx_reg, frame_idx_next;
   logic ack_reg, ack_next;
   logic fval_reg, fval_next;
   logic lval_reg, lval_next;
   logic busy_reg, busy_next;
   logic done_reg, done_next;

   logic                    msg_take;
   logic [11:0]             opcode;
   logic [N_FRAME_SIZE-1:0] arg;

   // A message is taken only while no ack is outstanding, so each one is consumed once.
   assign msg_take = bus.pc_msg_pending && !ack_reg;
   assign opcode   = bus.pc_msg[31:20];
   assign arg      = bus.pc_msg[19:0];

   always_comb begin
      state_next      = state_reg;
      blank_next      = blank_reg;
      line_next       = line_reg;
      clk_next        = clk_reg;
      frame_left_next = frame_left_reg;
      frame_idx_next  = frame_idx_reg;
      done_next       = 1'b0;

      case (state_reg)
         ST_STANDBY: ;
         ST_VBLANK: begin
            if (blank_reg == V_LAST) begin
               state_next = ST_HBLANK;
               blank_next = '0;
               line_next  = '0;
            end else begin
               blank_next = blank_reg + 1'b1;
            end
         end
         ST_HBLANK: begin
            if (blank_reg == H_LAST) begin
               state_next = ST_ACTIVE;
               blank_next = '0;
               clk_next   = '0;
            end else begin
               blank_next = blank_reg + 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (clk_reg == CLK_LAST) begin
               blank_next = '0;
               if (line_reg == LINE_LAST) begin
                  frame_left_next = frame_left_reg - 1'b1;
                  frame_idx_next  = frame_idx_reg + 1'b1;
                  if (frame_left_reg == N_FRAME_SIZE'(1)) begin
                     state_next = ST_STANDBY;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_VBLANK;
                  end
               end else begin
                  line_next  = line_reg + 1'b1;
                  state_next = ST_HBLANK;
               end
            end else begin
               clk_next = clk_reg + 1'b1;
            end
         end
         default: state_next = ST_STANDBY;
      endcase

      // Messages override the timing sequence; STOP beats a coincident frame end.
      if (msg_take) begin
         if (opcode == CL_OP_STOP && state_reg != ST_STANDBY) begin
            state_next = ST_STANDBY;
            done_next  = 1'b0;
         end else if (opcode == CL_OP_RUN && state_reg == ST_STANDBY && arg != '0) begin
            state_next      = ST_VBLANK;
            frame_left_next = arg;
            frame_idx_next  = '0;
            blank_next      = '0;
            line_next       = '0;
            clk_next        = '0;
         end
      end

      ack_next  = msg_take;
      fval_next = (state_next == ST_HBLANK) || (state_next == ST_ACTIVE);
      lval_next = (state_next == ST_ACTIVE);
      busy_next = (state_next != ST_STANDBY);
   end

   always_ff @(posedge cl_clk) begin
      if (reset) begin
         state_reg      <= ST_STANDBY;
         blank_reg      <= '0;
         line_reg       <= '0;
         clk_reg        <= '0;
         frame_left_reg <= '0;
         frame_idx_reg  <= '0;
         ack_reg        <= 1'b0;
         fval_reg       <= 1'b0;
         lval_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         blank_reg      <= blank_next;
         line_reg       <= line_next;
         clk_reg        <= clk_next;
         frame_left_reg <= frame_left_next;
         frame_idx_reg  <= frame_idx_next;
         ack_reg        <= ack_next;
         fval_reg       <= fval_next;
         lval_reg       <= lval_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
      end
   end

   // Fed with next-state values so the word lands in the same cycle as its lval.
   cl_frame_gen_pattern u_pattern (
      .clk       (cl_clk),
      .reset     (reset),
      .frame_idx (frame_idx_next),
      .line      (line_next),
      .clk_cnt   (clk_next),
      .lval      (lval_next),
      .data      (bus.cl_data)
   );

   assign bus.pc_msg_ack = ack_reg;
   assign bus.cl_fval    = fval_reg;
   assign bus.cl_lval    = lval_reg;
   assign bus.gen_busy   = busy_reg;
   assign bus.gen_done   = done_reg;

endmodule

// File: tb/tb_cl_frame_gen.sv
// Randomized scoreboard bench for cl_frame_gen: expected words/frames queued at stimulus, checked by a monitor.
module tb_cl_frame_gen;

   localparam int N_LINE  = 4;
   localparam int N_CLK   = 8;
   localparam int H_BLANK = 2;
   localparam int V_BLANK = 3;
   localparam int FLEN    = N_LINE * (H_BLANK + N_CLK);
   localparam int PERIOD  = V_BLANK + FLEN;
   localparam logic [11:0] OP_STOP = 12'h000;
   localparam logic [11:0] OP_RUN  = 12'h001;

   typedef struct {
      int len;
      bit last;
   } frame_exp_t;

   logic cl_clk = 1'b0;
   logic reset  = 1'b1;
   int   cyc    = 0;

   cl_frame_gen_if bus ();

   cl_frame_gen #(
      .N_LINE  (N_LINE),
      .N_CLK   (N_CLK),
      .H_BLANK (H_BLANK),
      .V_BLANK (V_BLANK)
   ) dut (
      .cl_clk (cl_clk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 cl_clk = ~cl_clk;
   always @(posedge cl_clk) cyc <= cyc + 1;

   logic [79:0] exp_data[$];
   frame_exp_t  exp_frames[$];
   int n_cmp = 0;
   int n_err = 0;
   bit abort = 1'b0;

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%b exp=%b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_word(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference pixel word straight from the documented field layout.
   function automatic logic [79:0] ref_word(input int f, input int l, input int c);
      logic [19:0] fi;
      logic [11:0] li;
      logic [9:0]  ci;
      fi = 20'(f);
      li = 12'(l);
      ci = 10'(c);
      return {8'hA5, fi, 4'h0, li, 6'h0, ci, ~fi};
   endfunction

   task automatic push_run(input int n);
      for (int f = 0; f < n; f++) begin
         for (int l = 0; l < N_LINE; l++)
            for (int c = 0; c < N_CLK; c++)
               exp_data.push_back(ref_word(f, l, c));
         exp_frames.push_back('{len: FLEN, last: (f == n - 1)});
      end
   endtask

   // Monitor: pops expected words on every lval cycle and frame records on every fval fall.
   logic pf = 1'b0, pl = 1'b0;
   int   flen = 0, lowlen = 0, gcnt = 0, llen = 0;
   bit   vgap_exp = 1'b0;
   initial begin : monitor
      frame_exp_t fe;
      logic fall;
      forever begin
         @(negedge cl_clk);
         fall = pf && !bus.cl_fval;
         if (bus.cl_lval) begin
            chk_bit("lval_inside_fval", bus.cl_fval, 1'b1);
            if (exp_data.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL extra_word act=%h exp=none (cycle %0d)", bus.cl_data, cyc);
            end else begin
               chk_word("pixel_data", bus.cl_data, exp_data.pop_front());
            end
         end else if (bus.cl_data != 80'h0) begin
            chk_word("data_idle_zero", bus.cl_data, 80'h0);
         end
         chk_bit("done_only_at_frame_end", bus.gen_done & ~fall, 1'b0);
         if (!pl && bus.cl_lval)
            chk_int("hblank_len", gcnt, H_BLANK);
         if (pl && !bus.cl_lval && !abort)
            chk_int("line_len", llen, N_CLK);
         if (!pf && bus.cl_fval) begin
            if (vgap_exp) chk_int("vblank_len", lowlen, V_BLANK);
            vgap_exp = 1'b0;
         end
         if (fall) begin
            if (abort) begin
               chk_bit("abort_no_done", bus.gen_done, 1'b0);
               abort    = 1'b0;
               vgap_exp = 1'b0;
            end else if (exp_frames.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL extra_frame act=%0d exp=none (cycle %0d)", flen, cyc);
            end else begin
               fe = exp_frames.pop_front();
               chk_int("fval_len", flen, fe.len);
               chk_bit("done_at_last_frame", bus.gen_done, fe.last);
               chk_bit("busy_at_frame_end", bus.gen_busy, !fe.last);
               vgap_exp = !fe.last;
            end
         end
         flen   = bus.cl_fval ? flen + 1 : 0;
         lowlen = bus.cl_fval ? 0 : lowlen + 1;
         gcnt   = (bus.cl_fval && !bus.cl_lval) ? gcnt + 1 : 0;
         llen   = bus.cl_lval ? llen + 1 : 0;
         pf     = bus.cl_fval;
         pl     = bus.cl_lval;
      end
   end

   task automatic send_msg(input logic [11:0] op, input logic [19:0] arg,
                           input bit is_stop, output int ack_cyc);
      @(posedge cl_clk); #1;
      bus.pc_msg_pending = 1'b1;
      bus.pc_msg         = {op, arg};
      ack_cyc            = -1;
      for (int k = 0; k < 6; k++) begin
         @(posedge cl_clk); #1;
         if (bus.pc_msg_ack) begin
            ack_cyc = cyc;
            break;
         end
      end
      chk_bit("ack_seen", ack_cyc >= 0, 1'b1);
      if (is_stop) begin
         chk_bit("stop_fval_low", bus.cl_fval, 1'b0);
         chk_bit("stop_lval_low", bus.cl_lval, 1'b0);
         abort = 1'b1;
         exp_data.delete();
         exp_frames.delete();
      end
      bus.pc_msg_pending = 1'b0;
      @(posedge cl_clk); #1;
      chk_bit("ack_one_cycle", bus.pc_msg_ack, 1'b0);
   endtask

   task automatic check_latency(input int ack_cyc);
      int r;
      r = -1;
      for (int k = 0; k < 20; k++) begin
         if (bus.cl_fval) begin
            r = cyc;
            break;
         end
         @(posedge cl_clk); #1;
      end
      chk_int("first_fval_latency", r - ack_cyc, V_BLANK);
   endtask

   task automatic wait_done(input int n);
      bit got;
      got = 1'b0;
      for (int k = 0; k < n * PERIOD + 50; k++) begin
         if (bus.gen_done) begin
            got = 1'b1;
            break;
         end
         @(posedge cl_clk); #1;
      end
      chk_bit("done_seen", got, 1'b1);
      chk_bit("busy_low_at_done", bus.gen_busy, 1'b0);
      @(negedge cl_clk); #1;
      chk_int("words_drained", exp_data.size(), 0);
      chk_int("frames_drained", exp_frames.size(), 0);
   endtask

   task automatic run_frames(input int n, input bit inject);
      int a, dummy;
      push_run(n);
      send_msg(OP_RUN, 20'(n), 1'b0, a);
      check_latency(a);
      if (inject) begin
         repeat ($urandom_range(5, 40)) @(posedge cl_clk);
         send_msg(OP_RUN, 20'($urandom_range(1, 9)), 1'b0, dummy);
         send_msg(12'h7, 20'($urandom), 1'b0, dummy);
      end
      $display("run n_frames=%0d inject=%0d", n, inject);
      wait_done(n);
   endtask

   initial begin : stim
      int a;
      bit found, quiet;
      bus.pc_msg_pending = 1'b0;
      bus.pc_msg         = 32'h0;

      repeat (3) @(posedge cl_clk);
      #1;
      chk_bit("rst_ack", bus.pc_msg_ack, 1'b0);
      chk_bit("rst_fval", bus.cl_fval, 1'b0);
      chk_bit("rst_lval", bus.cl_lval, 1'b0);
      chk_word("rst_data", bus.cl_data, 80'h0);
      chk_bit("rst_busy", bus.gen_busy, 1'b0);
      chk_bit("rst_done", bus.gen_done, 1'b0);
      reset = 1'b0;

      run_frames(1, 1'b0);
      run_frames(3, 1'b1);
      for (int it = 0; it < 4; it++) begin
         run_frames(int'($urandom_range(1, 3)), 1'b0);
         repeat ($urandom_range(0, 5)) @(posedge cl_clk);
      end

      // STOP in frame 1 line 2, then a fresh RUN must restart at frame_idx 0.
      push_run(3);
      send_msg(OP_RUN, 20'd3, 1'b0, a);
      found = 1'b0;
      for (int k = 0; k < 3 * PERIOD; k++) begin
         @(posedge cl_clk); #1;
         if (bus.cl_lval && bus.cl_data[71:52] == 20'd1 && bus.cl_data[47:36] == 12'd2) begin
            found = 1'b1;
            break;
         end
      end
      chk_bit("stop_trigger_found", found, 1'b1);
      send_msg(OP_STOP, 20'd0, 1'b1, a);
      quiet = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(posedge cl_clk); #1;
         if (bus.cl_fval || bus.cl_lval || bus.gen_busy || bus.gen_done) quiet = 1'b0;
      end
      chk_bit("stopped_quiet", quiet, 1'b1);
      $display("stop during frame 1 line 2 issued");
      run_frames(2, 1'b0);

      // Ignored messages in STANDBY: each acked once, outputs stay idle.
      send_msg(OP_RUN, 20'd0, 1'b0, a);
      send_msg(12'h7, 20'($urandom), 1'b0, a);
      send_msg(OP_STOP, 20'd0, 1'b0, a);
      quiet = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge cl_clk); #1;
         if (bus.cl_fval || bus.gen_busy || bus.gen_done) quiet = 1'b0;
      end
      chk_bit("ignored_msgs_idle", quiet, 1'b1);
      $display("ignored messages in standby issued");

      // Reset while ACTIVE with a pending RUN held through reset.
      push_run(2);
      send_msg(OP_RUN, 20'd2, 1'b0, a);
      found = 1'b0;
      for (int k = 0; k < PERIOD; k++) begin
         @(posedge cl_clk); #1;
         if (bus.cl_lval) begin
            found = 1'b1;
            break;
         end
      end
      chk_bit("reset_trigger_found", found, 1'b1);
      reset              = 1'b1;
      bus.pc_msg_pending = 1'b1;
      bus.pc_msg         = {OP_RUN, 20'd1};
      @(posedge cl_clk); #1;
      abort = 1'b1;
      exp_data.delete();
      exp_frames.delete();
      chk_bit("mid_rst_ack", bus.pc_msg_ack, 1'b0);
      chk_bit("mid_rst_fval", bus.cl_fval, 1'b0);
      chk_bit("mid_rst_lval", bus.cl_lval, 1'b0);
      chk_word("mid_rst_data", bus.cl_data, 80'h0);
      chk_bit("mid_rst_busy", bus.gen_busy, 1'b0);
      chk_bit("mid_rst_done", bus.gen_done, 1'b0);
      repeat (2) @(posedge cl_clk);
      #1;
      push_run(1);
      reset = 1'b0;
      a = -1;
      for (int k = 0; k < 6; k++) begin
         @(posedge cl_clk); #1;
         if (bus.pc_msg_ack) begin
            a = cyc;
            break;
         end
      end
      chk_bit("held_msg_acked", a >= 0, 1'b1);
      bus.pc_msg_pending = 1'b0;
      @(posedge cl_clk); #1;
      chk_bit("held_ack_once", bus.pc_msg_ack, 1'b0);
      check_latency(a);
      $display("reset in active, held run acked after release");
      wait_done(1);

      repeat (5) @(posedge cl_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
